// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// instruction_fetch_unit: RV32I IF stage owning the PC, the instruction-memory read
// port and the IF/ID register; squashes wrong-path fetches including in-flight misses.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PC_MUX_CONTROL,
    input  logic [31:0] BRANCH_OR_JUMP_ADDR,
    input  logic        REG_FLUSH,
    input  logic        HOLD,
    output logic [31:0] INSTR_MEM_ADDRESS,
    output logic        INSTR_MEM_READ,
    input  logic [31:0] INSTR_MEM_READDATA,
    input  logic        INSTR_MEM_BUSYWAIT,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_INSTR,
    output logic        IF_ID_VALID
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        DISCARD = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic        redir;
    logic [31:0] target;

    assign redir  = PC_MUX_CONTROL | REG_FLUSH;
    assign target = BRANCH_OR_JUMP_ADDR & ~32'h0000_0003;

    // Memory port depends only on registered PC and RESET, never on the redirect.
    assign INSTR_MEM_ADDRESS = pc_q;
    assign INSTR_MEM_READ    = ~RESET;

    assign IF_ID_PC    = ifid_pc_q;
    assign IF_ID_INSTR = ifid_instr_q;
    assign IF_ID_VALID = ifid_valid_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;

        if (!HOLD) begin
            ifid_pc_d    = 32'h0;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;

            unique case (state_q)
                RUN: begin
                    if (redir) begin
                        if (!INSTR_MEM_BUSYWAIT) begin
                            pc_d = target;
                        end else begin
                            // Keep PC (and so the memory address) stable until the miss retires.
                            pend_d  = target;
                            state_d = DISCARD;
                        end
                    end else if (!INSTR_MEM_BUSYWAIT) begin
                        ifid_pc_d    = pc_q;
                        ifid_instr_d = INSTR_MEM_READDATA;
                        ifid_valid_d = 1'b1;
                        pc_d         = pc_q + 32'd4;
                    end
                end
                DISCARD: begin
                    if (redir) begin
                        pend_d = target;
                        if (!INSTR_MEM_BUSYWAIT) begin
                            pc_d    = target;
                            state_d = RUN;
                        end
                    end else if (!INSTR_MEM_BUSYWAIT) begin
                        pc_d    = pend_q;
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= RUN;
            pc_q         <= RESET_VECTOR;
            pend_q       <= 32'h0;
            ifid_pc_q    <= 32'h0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// tb_instruction_fetch_unit: directed stimulus with a cycle-level reference model
// and literal spot checks.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        PC_MUX_CONTROL = 1'b0;
    logic [31:0] BRANCH_OR_JUMP_ADDR = 32'h0;
    logic        REG_FLUSH = 1'b0;
    logic        HOLD = 1'b0;
    logic [31:0] INSTR_MEM_ADDRESS;
    logic        INSTR_MEM_READ;
    logic [31:0] INSTR_MEM_READDATA;
    logic        INSTR_MEM_BUSYWAIT = 1'b0;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_INSTR;
    logic        IF_ID_VALID;

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign INSTR_MEM_READDATA = mem_word(INSTR_MEM_ADDRESS);

    always #5 CLK = ~CLK;

    instruction_fetch_unit #(
        .RESET_VECTOR(RV),
        .NOP_INSTR   (NOP)
    ) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .PC_MUX_CONTROL     (PC_MUX_CONTROL),
        .BRANCH_OR_JUMP_ADDR(BRANCH_OR_JUMP_ADDR),
        .REG_FLUSH          (REG_FLUSH),
        .HOLD               (HOLD),
        .INSTR_MEM_ADDRESS  (INSTR_MEM_ADDRESS),
        .INSTR_MEM_READ     (INSTR_MEM_READ),
        .INSTR_MEM_READDATA (INSTR_MEM_READDATA),
        .INSTR_MEM_BUSYWAIT (INSTR_MEM_BUSYWAIT),
        .IF_ID_PC           (IF_ID_PC),
        .IF_ID_INSTR        (IF_ID_INSTR),
        .IF_ID_VALID        (IF_ID_VALID)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: PC, "a redirect is waiting for a miss to retire", and IF/ID contents.
    logic [31:0] m_pc, m_pend, m_ipc, m_iins;
    logic        m_wait, m_ival, m_live;

    initial begin
        m_live = 1'b0;
        forever begin
            @(posedge CLK);
            begin
                logic        s_rst, s_hold, s_redir, s_done;
                logic [31:0] s_tgt;
                s_rst   = RESET;
                s_hold  = HOLD;
                s_redir = PC_MUX_CONTROL | REG_FLUSH;
                s_tgt   = {BRANCH_OR_JUMP_ADDR[31:2], 2'b00};
                s_done  = !INSTR_MEM_BUSYWAIT;
                if (s_rst) begin
                    m_pc = RV; m_wait = 1'b0; m_pend = 32'h0;
                    m_ipc = 32'h0; m_iins = NOP; m_ival = 1'b0;
                    m_live = 1'b1;
                end else if (m_live && !s_hold) begin
                    // Default outcome of any unfrozen cycle is a bubble.
                    m_ipc = 32'h0; m_iins = NOP; m_ival = 1'b0;
                    if (s_redir) begin
                        m_pend = s_tgt;
                        if (s_done) begin m_pc = s_tgt; m_wait = 1'b0; end
                        else m_wait = 1'b1;
                    end else if (m_wait) begin
                        if (s_done) begin m_pc = m_pend; m_wait = 1'b0; end
                    end else if (s_done) begin
                        m_ipc = m_pc; m_iins = mem_word(m_pc); m_ival = 1'b1;
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
            #1;
            if (m_live) begin
                chk("model_if_id_pc",    IF_ID_PC, m_ipc);
                chk("model_if_id_instr", IF_ID_INSTR, m_iins);
                chk("model_if_id_valid", {31'h0, IF_ID_VALID}, {31'h0, m_ival});
                chk("model_mem_addr",    INSTR_MEM_ADDRESS, m_pc);
                chk("model_mem_read",    {31'h0, INSTR_MEM_READ}, {31'h0, ~RESET});
            end
        end
    end

    task automatic tick(input logic rst, input logic hold, input logic busy,
                        input logic pcm, input logic fl, input logic [31:0] addr);
        @(negedge CLK);
        RESET = rst; HOLD = hold; INSTR_MEM_BUSYWAIT = busy;
        PC_MUX_CONTROL = pcm; REG_FLUSH = fl; BRANCH_OR_JUMP_ADDR = addr;
        @(posedge CLK);
        #2;
    endtask

    task automatic run1();
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        // Reset
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("rst_instr", IF_ID_INSTR, 32'h0000_0013);
        chk("rst_valid", {31'h0, IF_ID_VALID}, 32'h0);
        chk("rst_pc", IF_ID_PC, 32'h0);
        chk("rst_read", {31'h0, INSTR_MEM_READ}, 32'h0);
        chk("rst_addr", INSTR_MEM_ADDRESS, 32'h0);

        // Four hits
        for (int i = 0; i < 4; i++) begin
            run1();
            chk("hit_pc", IF_ID_PC, 32'(i * 4));
            chk("hit_valid", {31'h0, IF_ID_VALID}, 32'h1);
        end

        // Redirect on a hit at 0x10
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0200);
        chk("redir_bubble", {31'h0, IF_ID_VALID}, 32'h0);
        chk("redir_addr", INSTR_MEM_ADDRESS, 32'h0000_0200);
        run1();
        chk("redir_target_pc", IF_ID_PC, 32'h0000_0200);
        chk("redir_target_instr", IF_ID_INSTR, 32'hC0DE_0200);

        // Get to 0x20, then a 3-cycle miss with a redirect to 0x80 in the first busy cycle
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0020);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0080);
        chk("miss_addr_stable1", INSTR_MEM_ADDRESS, 32'h0000_0020);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("miss_addr_stable3", INSTR_MEM_ADDRESS, 32'h0000_0020);
        run1();
        chk("discard_drop_valid", {31'h0, IF_ID_VALID}, 32'h0);
        chk("discard_resume_addr", INSTR_MEM_ADDRESS, 32'h0000_0080);
        run1();
        chk("discard_target_pc", IF_ID_PC, 32'h0000_0080);

        // Two redirects during DISCARD; second target has low bits set
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0080);
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0102);
        run1();
        chk("latest_wins_addr", INSTR_MEM_ADDRESS, 32'h0000_0100);
        run1();
        chk("latest_wins_pc", IF_ID_PC, 32'h0000_0100);

        // HOLD with redirect and no busywait
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0040);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0040);
        chk("hold_ifid_pc", IF_ID_PC, 32'h0000_0100);
        chk("hold_valid", {31'h0, IF_ID_VALID}, 32'h1);
        chk("hold_addr", INSTR_MEM_ADDRESS, 32'h0000_0104);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0040);
        chk("post_hold_addr", INSTR_MEM_ADDRESS, 32'h0000_0040);
        run1();
        chk("post_hold_pc", IF_ID_PC, 32'h0000_0040);

        // Plain miss of 2 cycles
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("miss_bubble", {31'h0, IF_ID_VALID}, 32'h0);
        run1();
        chk("miss_load_pc", IF_ID_PC, 32'h0000_0044);

        // Redirect in DISCARD retiring on the same edge as the miss
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0300);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0400);
        chk("discard_redir_done_addr", INSTR_MEM_ADDRESS, 32'h0000_0400);

        // PC wrap
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
        run1();
        chk("wrap_pc", IF_ID_PC, 32'hFFFF_FFFC);
        chk("wrap_addr", INSTR_MEM_ADDRESS, 32'h0000_0000);
        run1();
        chk("wrap_next_pc", IF_ID_PC, 32'h0000_0000);

        // Reset during DISCARD
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0300);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("midmiss_rst_addr", INSTR_MEM_ADDRESS, 32'h0000_0000);
        chk("midmiss_rst_valid", {31'h0, IF_ID_VALID}, 32'h0);
        chk("midmiss_rst_read", {31'h0, INSTR_MEM_READ}, 32'h0);
        run1();
        chk("after_rst_pc", IF_ID_PC, 32'h0000_0000);
        chk("after_rst_valid", {31'h0, IF_ID_VALID}, 32'h1);
        run1();
        chk("after_rst_seq", IF_ID_PC, 32'h0000_0004);

        @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction-fetch stage of the 5-stage RV32I pipeline: it owns the program counter, drives the instruction-memory/cache read port and loads the IF/ID pipeline register. It consumes the redirect outputs of the EX-stage jump/branch controller: the PC-select, the target address and the flush request. It squashes wrong-path fetches, including one still in flight in a slow cache miss, so only correct-path instructions reach decode.

## Interface
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013: bubble encoding (ADDI x0,x0,0) placed in IF/ID on flush or stall.
- CLK  input  1  pipeline clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- PC_MUX_CONTROL  input  1  redirect request from the jump controller (branch taken or jump).
- BRANCH_OR_JUMP_ADDR  input  32  redirect target.
- REG_FLUSH  input  1  flush request from the jump controller; treated as OR with PC_MUX_CONTROL.
- HOLD  input  1  global pipeline freeze (data-cache busywait / hazard unit).
- INSTR_MEM_ADDRESS  output  32  fetch address, equal to PC.
- INSTR_MEM_READ  output  1  read request; equal to ~RESET.
- INSTR_MEM_READDATA  input  32  instruction word; valid in any cycle with READ=1 and BUSYWAIT=0.
- INSTR_MEM_BUSYWAIT  input  1  memory not ready; address must stay stable while high.
- IF_ID_PC  output  32  PC of the instruction in IF/ID.
- IF_ID_INSTR  output  32  instruction in IF/ID.
- IF_ID_VALID  output  1  1 = real instruction, 0 = bubble.

## Operation
- Internal state: PC[31:0], state ∈ {RUN, DISCARD}, PENDING_ADDR[31:0].
- Redirect is defined as REDIR = PC_MUX_CONTROL | REG_FLUSH. The target used is {BRANCH_OR_JUMP_ADDR[31:2], 2'b00}, with the low bits forced to zero.
- Sequential PC is PC+4, modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0.
- Priority per edge: RESET > HOLD > redirect > normal fetch.
- HOLD=1: PC, state, PENDING_ADDR and IF/ID are all unchanged. Any memory response and any redirect in that cycle are ignored; the EX stage re-presents the redirect after the hold.
- RUN, REDIR=1, BUSYWAIT=0: PC <= target. IF/ID <= bubble, discarding the fetched word. State stays RUN.
- RUN, REDIR=1, BUSYWAIT=1: PENDING_ADDR <= target, state <= DISCARD, IF/ID <= bubble. PC is held so the address seen by memory stays stable.
- RUN, REDIR=0, BUSYWAIT=0: IF_ID_PC <= PC, IF_ID_INSTR <= READDATA, IF_ID_VALID <= 1, PC <= PC+4.
- RUN, REDIR=0, BUSYWAIT=1: PC held, IF/ID <= bubble.
- DISCARD, REDIR=1: PENDING_ADDR <= new target (latest wins), IF/ID <= bubble. If BUSYWAIT=0 in the same cycle, PC <= new target and state <= RUN.
- DISCARD, REDIR=0, BUSYWAIT=0: the returned word is dropped, PC <= PENDING_ADDR, state <= RUN, IF/ID <= bubble.
- DISCARD, REDIR=0, BUSYWAIT=1: hold everything, IF/ID <= bubble.
- Bubble: IF_ID_INSTR = NOP_INSTR, IF_ID_VALID = 0, IF_ID_PC = 0.

## Timing
- Reset values, one edge after RESET=1: PC = RESET_VECTOR, state = RUN, PENDING_ADDR = 0, IF_ID_PC = 0, IF_ID_INSTR = NOP_INSTR, IF_ID_VALID = 0.
- While RESET=1, INSTR_MEM_READ = 0. Deasserting RESET starts a fetch of RESET_VECTOR that same cycle.
- Reset asserted during DISCARD or a miss aborts it: the pending redirect is lost and PC returns to RESET_VECTOR.
- Fetch latency on a hit: the instruction at PC appears in IF/ID on the next edge, giving a throughput of 1 instruction/cycle.
- Miss of N busy cycles: N bubbles, then the instruction is loaded on the edge where BUSYWAIT=0.
- Redirect penalty, hit case: the target is fetched in the cycle after the REDIR edge. Exactly one bubble is inserted by this block; the EX-side flush of ID/EX is handled elsewhere.
- Redirect penalty, miss case: the remaining miss cycles plus one cycle; no wrong-path instruction ever gets IF_ID_VALID=1.
- INSTR_MEM_ADDRESS and INSTR_MEM_READ are combinational from registered PC and RESET. There is no combinational path from REDIR to the memory port.

## Test plan
- Reset, then 4 hit cycles with memory returning PC-tagged words → IF_ID_PC sequence 0x0, 0x4, 0x8, 0xC, VALID=1 each cycle, and IF/ID = NOP/VALID=0 immediately after reset.
- Redirect at PC=0x10 on a hit, target 0x200 → next IF/ID is a bubble, fetch address is 0x200 the following cycle, then IF_ID_PC = 0x200 with VALID=1.
- Miss at 0x20 with BUSYWAIT high 3 cycles, redirect to 0x80 in the first busy cycle → address stays 0x20 during the miss, the returned word is dropped, PC = 0x80, and no VALID=1 with PC 0x20.
- Two redirects during DISCARD (0x80, then 0x100) → fetch resumes at 0x100.
- HOLD high 2 cycles together with REDIR and BUSYWAIT=0 → PC and IF/ID frozen; after HOLD drops, a re-presented redirect to 0x40 is taken normally.
- PC = 0xFFFF_FFFC on a hit, no redirect → next fetch address is 0x0000_0000; RESET asserted mid-miss → PC = RESET_VECTOR, VALID=0.
